fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit CPU. Sits between the program counter logic and decode.
- Drives the 8-bit address into the combinational instruction memory and captures the 13-bit word {opcode[12:8], operand[7:0]} the same cycle.
- Buffers fetched words with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch redirects from execute. Predecodes unconditional JMP so the following fetch goes straight to the jump target.

Parameters:
- DEPTH, 2, number of fetch-buffer entries; power of two, ≥2.
- RESET_PC, 8'd0, PC value loaded on reset.
- OPC_JMP, 5'b01111, opcode of the unconditional jump; its operand is the absolute target.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable; 0 freezes the PC and stops pushes (pops continue).
- im_addr  out  8  address to instruction memory; always equals pc.
- im_dout  in  13  instruction word returned combinationally for im_addr.
- br_taken  in  1  redirect request from execute, single-cycle pulse.
- br_target  in  8  redirect PC, valid when br_taken=1.
- inst_valid  out  1  head of the buffer holds a valid instruction.
- inst  out  13  head instruction word.
- inst_pc  out  8  PC of the head instruction.
- inst_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, count=0, rd/wr pointers=0.
  - After reset: inst_valid=0, inst=13'd0, inst_pc=8'd0 (muxed to zero when count=0), im_addr=RESET_PC.
- pop = inst_valid & inst_ready.
- push = run & ~br_taken & (count<DEPTH | pop).
  - Pushing into a full buffer is allowed in the same cycle as a pop; count is unchanged.
- On push:
  - Entry {pc, im_dout} is written at wr_ptr.
  - Next pc is im_dout[7:0] if im_dout[12:8]==OPC_JMP, otherwise pc+1 (mod 256, so 8'hFF wraps to 8'h00).
  - The JMP word is still pushed; decode treats it as a no-op.
- No push, no redirect: pc holds.
- br_taken=1 has priority over everything in that cycle:
  - pc <= br_target; count <= 0; both pointers <= 0.
  - No push that cycle.
  - A pop in the same cycle still counts as accepted by decode; the buffer is discarded regardless.
  - First push of the target occurs the next cycle if run=1.
- Latency:
  - Word at address A is visible on inst one cycle after the edge on which pc==A and push=1.
  - Steady-state throughput is 1 instruction/cycle with inst_ready held high.
- inst, inst_pc and inst_valid are registered or FIFO-head values only. No combinational path from im_dout or inst_ready to them.
- run=0 with a non-empty buffer: decode drains the entries; inst_valid falls after the last pop.
- Reset asserted mid-operation: all state clears immediately; buffered entries are lost.
- Stable-output rule: inst/inst_pc must not change while inst_valid=1 and inst_ready=0, unless br_taken flushes.

Decomposition:
- Shared cpu package holds:
  - opcode constants, including OPC_JMP;
  - width constants INST_W=13, ADDR_W=8, OPC_W=5;
  - the fetch entry typedef {pc, inst}.
- One sub-module, fetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush, count, and head outputs.
- The PC, next-PC mux and JMP predecode stay in fetch_unit.

Test Plan:
- Reset, then run=1, inst_ready=1, memory words non-JMP at 0..3 → inst_pc sequence 0,1,2,3 on consecutive cycles starting one cycle after the first push; inst_valid continuous.
- inst_ready=0 for 4 cycles from pc=0 → exactly 2 entries buffered (pc 0,1); im_addr holds at 2; on ready=1, inst_pc 0,1,2 delivered back-to-back with no bubble.
- Word at addr 18 = {01111, 8'd8} → inst_pc 18 delivered, next inst_pc 8, no bubble; word at 8'hFF non-JMP → next inst_pc 8'h00.
- br_taken=1, br_target=8'h40 while buffer full → inst_valid=0 next cycle; next delivered inst_pc=8'h40; stale entries never appear.
- run=0 with 2 buffered entries and ready=1 → both delivered, then inst_valid=0, im_addr frozen; run=1 resumes at the frozen address.
- rst_n asserted asynchronously mid-stream, between clock edges → inst_valid=0 and im_addr=0 immediately; after release, fetch restarts at pc 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode constants and the fetch-buffer entry type.
package cpu_pkg;
   localparam int INST_W = 13;
   localparam int ADDR_W = 8;
   localparam int OPC_W  = 5;
   localparam logic [OPC_W-1:0] OPC_NOP = 5'b00000;
   localparam logic [OPC_W-1:0] OPC_LDA = 5'b00001;
   localparam logic [OPC_W-1:0] OPC_STA = 5'b00010;
   localparam logic [OPC_W-1:0] OPC_ADD = 5'b00011;
   localparam logic [OPC_W-1:0] OPC_BEQ = 5'b01110;
   localparam logic [OPC_W-1:0] OPC_JMP = 5'b01111;
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry fetch buffer with push/pop/flush; head reads as zero when empty.
module fetch_fifo import cpu_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);
   fetch_entry_t mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      rd_d  = flush ? '0 : pop  ? rd_q + PW'(1) : rd_q;
      wr_d  = flush ? '0 : push ? wr_q + PW'(1) : wr_q;
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
   // Storage needs no reset: an empty buffer masks the head to zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= din;
   end
   assign count = cnt_q;
   assign head  = (cnt_q == '0) ? '0 : mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, next-PC mux with JMP predecode, and fetch buffer feeding decode.
module fetch_unit #(
   parameter int DEPTH = 2,
   parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = 8'd0,
   parameter logic [cpu_pkg::OPC_W-1:0]  OPC_JMP  = cpu_pkg::OPC_JMP
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       run,
   output logic [cpu_pkg::ADDR_W-1:0] im_addr,
   input  logic [cpu_pkg::INST_W-1:0] im_dout,
   input  logic                       br_taken,
   input  logic [cpu_pkg::ADDR_W-1:0] br_target,
   output logic                       inst_valid,
   output logic [cpu_pkg::INST_W-1:0] inst,
   output logic [cpu_pkg::ADDR_W-1:0] inst_pc,
   input  logic                       inst_ready
);
   import cpu_pkg::*;
   localparam int CW = $clog2(DEPTH + 1);
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CW-1:0] count;
   logic pop, push, jmp;
   fetch_entry_t head, din;
   always_comb begin
      pop  = inst_valid & inst_ready;
      push = run & ~br_taken & ((count < CW'(DEPTH)) | pop);
      jmp  = im_dout[INST_W-1:ADDR_W] == OPC_JMP;
      din  = '{pc: pc_q, inst: im_dout};
      pc_d = br_taken ? br_target : !push ? pc_q : jmp ? im_dout[ADDR_W-1:0] : pc_q + 8'd1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (br_taken),
      .din   (din),
      .count (count),
      .head  (head)
   );
   assign im_addr    = pc_q;
   assign inst_valid = count != '0;
   assign inst       = head.inst;
   assign inst_pc    = head.pc;
endmodule
